mem_port_arbiter: RTL and testbench

Single-cycle arbiter that shares one single-port 32-bit SRAM between the instruction-fetch requester and the data-memory requester of the pipelined CPU. It sits between the CPU's `im_*` / `dm_*` ports and a unified SRAM macro. Each cycle it grants at most one access. It returns read data one cycle later, tagged to the requester that issued it, and enforces bounded starvation for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port SRAM between instruction fetch and data memory.
// DM wins conflicts unless IF has been denied STARVE_MAX consecutive cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_web,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_bweb,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_bweb,
    input  logic [DATA_W-1:0] sram_dout
);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnDm} own_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt_d;
    own_e       r_rsp_own;
    own_e       w_rsp_own_d;
    logic       w_starved;
    logic       w_if_win;
    logic       w_dm_win;

    // Ungated winners feed state; reset holds the registers regardless.
    assign w_starved = (r_starve_cnt == StarveMax);
    assign w_if_win  = if_req && (!dm_req || w_starved);
    assign w_dm_win  = dm_req && !w_if_win;

    assign if_gnt = rst && w_if_win;
    assign dm_gnt = rst && w_dm_win;

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        sram_bweb = '1;
        if (if_gnt) begin
            sram_ceb  = 1'b0;
            sram_addr = if_addr;
        end else if (dm_gnt) begin
            sram_ceb  = 1'b0;
            sram_web  = dm_web;
            sram_addr = dm_addr;
            sram_din  = dm_wdata;
            sram_bweb = dm_bweb;
        end
    end

    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        w_rsp_own_d    = OwnNone;
        if (!if_req || w_if_win) begin
            w_starve_cnt_d = '0;
        end else if (r_starve_cnt < StarveMax) begin
            w_starve_cnt_d = r_starve_cnt + 4'd1;
        end
        // Writes return nothing, so only reads claim the response slot.
        if (w_if_win) begin
            w_rsp_own_d = OwnIf;
        end else if (w_dm_win && dm_web) begin
            w_rsp_own_d = OwnDm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_rsp_own    <= OwnNone;
        end else begin
            r_starve_cnt <= w_starve_cnt_d;
            r_rsp_own    <= w_rsp_own_d;
        end
    end

    assign if_rvalid = (r_rsp_own == OwnIf);
    assign dm_rvalid = (r_rsp_own == OwnDm);
    assign if_rdata  = if_rvalid ? sram_dout : '0;
    assign dm_rdata  = dm_rvalid ? sram_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with an SRAM model and a reference model
// of grant order, starvation bound and read returns.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_web;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_bweb;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        sram_ceb;
    logic        sram_web;
    logic [13:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_bweb;
    logic [31:0] sram_dout;

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          denied   = 0;
    int          pend_own = 0;  // 0 none, 1 IF, 2 DM
    logic [31:0] pend_data = '0;
    logic        m_if_gnt = 1'b0;
    logic        m_dm_gnt = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(14),
        .DATA_W(32),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_web(dm_web),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_bweb(dm_bweb),
        .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .sram_ceb(sram_ceb),
        .sram_web(sram_web),
        .sram_addr(sram_addr),
        .sram_din(sram_din),
        .sram_bweb(sram_bweb),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_addr] = (mem[sram_addr] & sram_bweb) | (sram_din & ~sram_bweb);
            else sram_dout <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_if(input logic req, input logic [13:0] a);
        if_req  = req;
        if_addr = a;
    endtask

    task automatic set_dm(input logic req, input logic web, input logic [13:0] a,
                          input logic [31:0] wd, input logic [31:0] bw);
        dm_req   = req;
        dm_web   = web;
        dm_addr  = a;
        dm_wdata = wd;
        dm_bweb  = bw;
    endtask

    // Called just after a falling edge; checks this cycle, advances the model.
    task automatic tick(input logic drop_rst = 1'b0);
        logic eif;
        logic edm;
        #1;
        eif = rst && if_req && (!dm_req || denied >= SMAX);
        edm = rst && dm_req && !eif;
        check("if_gnt", if_gnt, eif);
        check("dm_gnt", dm_gnt, edm);
        check("sram_ceb", sram_ceb, !(eif || edm));
        check("sram_web", sram_web, edm ? dm_web : 1'b1);
        check("sram_addr", sram_addr, eif ? if_addr : (edm ? dm_addr : 14'h0));
        if (!eif) check("sram_din", sram_din, edm ? dm_wdata : 32'h0);
        check("sram_bweb", sram_bweb, edm ? dm_bweb : 32'hFFFF_FFFF);
        check("if_rvalid", if_rvalid, pend_own == 1);
        check("dm_rvalid", dm_rvalid, pend_own == 2);
        check("if_rdata", if_rdata, (pend_own == 1) ? pend_data : 32'h0);
        check("dm_rdata", dm_rdata, (pend_own == 2) ? pend_data : 32'h0);
        m_if_gnt = eif;
        m_dm_gnt = edm;
        if (drop_rst) begin
            rst = 1'b0;
            #1;
        end
        @(posedge clk);
        if (!rst) begin
            denied   = 0;
            pend_own = 0;
        end else begin
            if (if_req && !eif) denied = (denied < SMAX) ? denied + 1 : denied;
            else denied = 0;
            if (eif) begin
                pend_own  = 1;
                pend_data = ref_mem[if_addr];
            end else if (edm && dm_web) begin
                pend_own  = 2;
                pend_data = ref_mem[dm_addr];
            end else begin
                pend_own = 0;
            end
            if (edm && !dm_web)
                ref_mem[dm_addr] = (ref_mem[dm_addr] & dm_bweb) | (dm_wdata & ~dm_bweb);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        mem[16]     = 32'h0000_0013;
        ref_mem[16] = 32'h0000_0013;

        // Reset with both requesting, then DM first after release
        rst = 1'b0;
        set_if(1'b1, 14'h0003);
        set_dm(1'b1, 1'b1, 14'h0005, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        tick();
        set_if(1'b0, 14'h0);
        tick();

        // Lone IF read
        set_if(1'b1, 14'h0010);
        tick();
        set_if(1'b0, 14'h0);
        #1 check("lone_if_rdata", if_rdata, 32'h0000_0013);
        tick();

        // Conflict: DM write beats IF, IF follows, then read back
        set_if(1'b1, 14'h0011);
        set_dm(1'b1, 1'b0, 14'h0020, 32'hDEAD_BEEF, 32'hFFFF_0000);
        tick();
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        tick();
        set_if(1'b0, 14'h0);
        set_dm(1'b1, 1'b1, 14'h0020, 32'h0, 32'hFFFF_FFFF);
        tick();
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        #1 check("wr_low_half", dm_rdata[15:0], 16'hBEEF);
        tick();

        // Starvation: IF held under continuous DM reads, two full rounds
        set_if(1'b1, 14'h0040);
        for (int i = 0; i < 2 * (SMAX + 1); i++) begin
            set_dm(1'b1, 1'b1, 14'(i + 8'h50), 32'h0, 32'hFFFF_FFFF);
            tick();
        end
        set_if(1'b0, 14'h0);
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        tick();

        // Alternating reads IF/DM/IF
        set_if(1'b1, 14'h0030);
        tick();
        set_if(1'b0, 14'h0);
        set_dm(1'b1, 1'b1, 14'h0031, 32'h0, 32'hFFFF_FFFF);
        tick();
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        set_if(1'b1, 14'h0032);
        tick();
        set_if(1'b0, 14'h0);
        tick();

        // Reset mid-read drops the response
        set_dm(1'b1, 1'b1, 14'h0044, 32'h0, 32'hFFFF_FFFF);
        tick(1'b1);
        set_dm(1'b0, 1'b1, 14'h0, 32'h0, 32'hFFFF_FFFF);
        tick();
        rst = 1'b1;
        tick();
        tick();

        // Randomised traffic honouring the hold-until-granted protocol
        for (int c = 0; c < 400; c++) begin
            if (!(if_req && !m_if_gnt)) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = 14'($urandom_range(0, 255));
            end
            if (!(dm_req && !m_dm_gnt)) begin
                dm_req   = ($urandom_range(0, 99) < 60);
                dm_web   = 1'($urandom_range(0, 1));
                dm_addr  = 14'($urandom_range(0, 255));
                dm_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       dm_bweb = 32'h0000_0000;
                    1:       dm_bweb = 32'hFFFF_0000;
                    2:       dm_bweb = 32'h0000_FFFF;
                    default: dm_bweb = $urandom;
                endcase
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
